ccff_bitstream_loader: RTL and testbench
========================================

// Module: ccff_bitstream_loader
// PURPOSE
//  Upstream driver of the IO/logic-tile configuration chain. Takes bitstream words over a
//  valid/ready port, serialises them MSB-first onto ccff_head and raises ccff_shift_en on
//  each shift cycle. ccff_shift_en drives the external integrated clock gate on the chain's
//  prog_clk. Reports busy/done; can optionally verify the chain by CRC recirculation.
// PARAMETERS
//  CHAIN_LEN  4   total config flops between ccff_head and ccff_tail (>=1)
//  WORD_W     8   bitstream word width (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)  localparam, bit-counter width
// PORTS
//  prog_clk        in   1       single clock, rising edge
//  pReset_n        in   1       asynchronous active-low reset
//  cfg_start       in   1       1-cycle request to begin a load; ignored unless IDLE
//  cfg_word_valid  in   1       word available
//  cfg_word        in   WORD_W  bitstream word, MSB shifted first
//  cfg_word_ready  out  1       word accepted when valid&ready at rising edge
//  ccff_head       out  1       serial data into chain
//  ccff_tail       in   1       serial data out of chain (used only with CCFF_VERIFY_EN)
//  ccff_shift_en   out  1       chain clock enable, registered
//  cfg_busy        out  1       high in any state except IDLE
//  cfg_done        out  1       1-cycle pulse when load (and verify) completes
//  cfg_error       out  1       sticky CRC mismatch flag, cleared by next cfg_start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-load forces shift_en
//   low at once. The chain's contents are then undefined and the host must reload.
//  FSM: IDLE -start-> LOAD -accept-> SHIFT -(bits of word used, count<CHAIN_LEN)-> LOAD
//   SHIFT -(count==CHAIN_LEN)-> VERIFY (macro) or DONE; VERIFY -(CHAIN_LEN shifts)-> DONE;
//   DONE -> IDLE.
//  Timing: cfg_start at edge N puts the FSM in LOAD after edge N; cfg_word_ready is high only in LOAD.
//  SHIFT: ccff_head and ccff_shift_en are registered. The chain captures ccff_head at every
//   rising edge where ccff_shift_en=1. One bit per cycle, no gaps within a word.
//   A 1-cycle bubble (shift_en=0) occurs per LOAD.
//  Bit count: on reaching CHAIN_LEN, remaining bits of the current word are discarded, with no
//   further ready. If CHAIN_LEN is not a multiple of WORD_W, the last word is partially used.
//  DONE: cfg_done=1 for exactly one cycle; busy drops the cycle after.
//  cfg_start while busy: ignored, with no effect on state or counters.
//  cfg_word_valid outside LOAD: ignored, and the word is held by the source.
// CONFIGURATION
//  CCFF_VERIFY_EN defined:
//   - During SHIFT a serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) folds each sent bit.
//   - VERIFY issues CHAIN_LEN more shifts with ccff_head = ccff_tail (combinational mux),
//     so the chain rotates back to its loaded contents.
//   - The rx CRC folds ccff_tail sampled at each shift edge. At the end, tx!=rx sets
//     cfg_error, asserted with cfg_done.
//  CCFF_VERIFY_EN undefined: no VERIFY state, no CRC logic, cfg_error tied 0,
//   ccff_tail unused.
// STRUCTURE
//  Package ccff_loader_pkg: state enum (IDLE, LOAD, SHIFT, VERIFY, DONE), CRC_POLY, CRC_INIT.
//  Sub-module ccff_crc16_serial (clr, en, bit_in -> crc[15:0]) is instantiated twice
//   (tx and rx), and only under the macro.
// TESTING
//  1 CHAIN_LEN=4, WORD_W=8, word 0xA5: ccff_head bits 1,0,1,0 over 4 shift_en cycles,
//    ready low for the rest of the load, cfg_done 1 cycle after the last shift, chain holds 1010.
//  2 CHAIN_LEN=12, WORD_W=8, words 0x3C,0xF0: two LOADs, 12 shifts, low nibble of 0xF0
//    discarded, one shift_en bubble between words.
//  3 Macro on, CHAIN_LEN=4 with behavioural chain, word 0xC0: 4+4 shifts,
//    chain ends as 1100, cfg_error=0 with cfg_done.
//  4 Macro on, chain model flips one tail bit during VERIFY: cfg_error=1 with cfg_done;
//    the next cfg_start clears it.
//  5 pReset_n low in mid-SHIFT (bit 2 of 4): shift_en, busy and head go to 0 immediately;
//    a new start reloads all 4 bits.
//  6 cfg_start pulsed during SHIFT and valid held during SHIFT: no restart, and the word is
//    accepted only at the next LOAD.

Source files
------------

// File: rtl/ccff_bitstream_loader_pkg.sv
// rtl/ccff_bitstream_loader_pkg.sv - loader FSM states and CRC-16-CCITT constants
// Shared by the loader top and the serial CRC helper.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One MSB-first serial step of CRC-16-CCITT.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// rtl/ccff_bitstream_loader_if.sv - bitstream word valid/ready port
// The source drives valid and word; the loader answers with ready.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic              cfg_word_valid;
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_word_ready;

    modport master (
        output cfg_word_valid,
        output cfg_word,
        input  cfg_word_ready
    );

    modport slave (
        input  cfg_word_valid,
        input  cfg_word,
        output cfg_word_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader_crc16.sv
// rtl/ccff_bitstream_loader_crc16.sv - serial CRC-16-CCITT accumulator (CCFF_VERIFY_EN builds only)
// Folds one bit per enabled cycle; clr reloads the initial value.
`ifdef CCFF_VERIFY_EN
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] r_crc;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_crc <= CRC_INIT;
        end else if (clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;
endmodule
`endif

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises bitstream words MSB-first into the config chain
// CCFF_VERIFY_EN adds a rotate-back pass that compares tx/rx CRCs of the chain contents.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8
)(
    input  logic                    prog_clk,
    input  logic                    pReset_n,
    input  logic                    cfg_start,
    ccff_bitstream_loader_if.slave  s_word,
    output logic                    ccff_head,
    input  logic                    ccff_tail,
    output logic                    ccff_shift_en,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WORD_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_bit_idx;   // word bit currently presented on ccff_head
    logic [CNT_W-1:0]  r_count;     // shifts completed in the current phase
    logic              r_head;
    logic              r_shift_en;
    logic              w_start;
    logic              w_accept;
    logic              w_last_shift;
    logic              w_last_bit;
    logic              w_head_nxt;
    logic              w_shift_en_nxt;
    logic [IDX_W-1:0]  w_idx_m1;

    assign w_start      = cfg_start && (r_state == IDLE);
    assign w_accept     = (r_state == LOAD) && s_word.cfg_word_valid;
    assign w_last_shift = (r_count == LAST_CNT);
    assign w_last_bit   = (r_bit_idx == '0);
    assign w_idx_m1     = r_bit_idx - 1'b1;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (cfg_start) w_state_nxt = LOAD;
            LOAD:  if (s_word.cfg_word_valid) w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_last_shift) begin
`ifdef CCFF_VERIFY_EN
                    w_state_nxt = VERIFY;
`else
                    w_state_nxt = DONE;
`endif
                end else if (w_last_bit) begin
                    w_state_nxt = LOAD;
                end
            end
`ifdef CCFF_VERIFY_EN
            VERIFY: if (w_last_shift) w_state_nxt = DONE;
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Head and shift enable are computed one cycle ahead and registered.
    always_comb begin
        w_shift_en_nxt        = 1'b0;
        w_head_nxt            = 1'b0;
        s_word.cfg_word_ready = 1'b0;
        cfg_busy              = (r_state != IDLE);
        cfg_done              = (r_state == DONE);
        case (r_state)
            LOAD: begin
                s_word.cfg_word_ready = 1'b1;
                if (s_word.cfg_word_valid) begin
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = s_word.cfg_word[WORD_W-1];
                end
            end
            SHIFT: begin
`ifdef CCFF_VERIFY_EN
                w_shift_en_nxt = w_last_shift || !w_last_bit;
`else
                w_shift_en_nxt = !w_last_shift && !w_last_bit;
`endif
                if (!w_last_shift && !w_last_bit) begin
                    w_head_nxt = r_word[w_idx_m1];
                end
            end
`ifdef CCFF_VERIFY_EN
            VERIFY: w_shift_en_nxt = !w_last_shift;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_word     <= '0;
            r_bit_idx  <= '0;
            r_count    <= '0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_shift_en <= w_shift_en_nxt;
            if (w_start) begin
                r_count <= '0;
            end
            if (w_accept) begin
                r_word    <= s_word.cfg_word;
                r_bit_idx <= TOP_IDX;
            end else if (r_state == SHIFT) begin
                r_bit_idx <= w_idx_m1;
                r_count   <= w_last_shift ? '0 : r_count + 1'b1;
            end
`ifdef CCFF_VERIFY_EN
            else if (r_state == VERIFY) begin
                r_count <= r_count + 1'b1;
            end
`endif
        end
    end

    assign ccff_shift_en = r_shift_en;

`ifdef CCFF_VERIFY_EN
    logic [15:0] w_tx_crc;
    logic [15:0] w_rx_crc;
    logic        w_tx_en;
    logic        w_rx_en;
    logic        w_mismatch;
    logic        r_error;

    // Rotating the chain returns its bits in send order, so both CRCs must agree.
    assign ccff_head  = (r_state == VERIFY) ? ccff_tail : r_head;
    assign w_tx_en    = (r_state == SHIFT) && r_shift_en;
    assign w_rx_en    = (r_state == VERIFY) && r_shift_en;
    assign w_mismatch = (w_tx_crc != w_rx_crc);

    ccff_crc16_serial u_tx_crc (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clr      (w_start),
        .en       (w_tx_en),
        .bit_in   (r_head),
        .crc      (w_tx_crc)
    );

    ccff_crc16_serial u_rx_crc (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clr      (w_start),
        .en       (w_rx_en),
        .bit_in   (ccff_tail),
        .crc      (w_rx_crc)
    );

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_error <= 1'b0;
        end else if (w_start) begin
            r_error <= 1'b0;
        end else if ((r_state == DONE) && w_mismatch) begin
            r_error <= 1'b1;
        end
    end

    assign cfg_error = r_error || ((r_state == DONE) && w_mismatch);
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign ccff_head     = r_head;
    assign cfg_error     = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - bench for ccff_bitstream_loader with 4- and 12-flop chains
// Behavioural chains sit behind each DUT; expected bits come from concatenated words.
module tb_ccff_bitstream_loader;
    localparam int LA = 4;
    localparam int LB = 12;
    localparam int W  = 8;
`ifdef CCFF_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] start   = 2'b00;
    logic [1:0] v_valid = 2'b00;
    logic [7:0] v_word [2];
    logic [1:0] mon_clr = 2'b00;
    logic [1:0] flip    = 2'b00;
    wire  [1:0] ready, head, tail, sh_en, busy, done, err;

    always #5 clk = ~clk;

    ccff_bitstream_loader_if #(.WORD_W(W)) if_a ();
    ccff_bitstream_loader_if #(.WORD_W(W)) if_b ();

    assign if_a.cfg_word_valid = v_valid[0];
    assign if_a.cfg_word       = v_word[0];
    assign ready[0]            = if_a.cfg_word_ready;
    assign if_b.cfg_word_valid = v_valid[1];
    assign if_b.cfg_word       = v_word[1];
    assign ready[1]            = if_b.cfg_word_ready;

    ccff_bitstream_loader #(.CHAIN_LEN(LA), .WORD_W(W)) u_dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .cfg_start(start[0]), .s_word(if_a.slave),
        .ccff_head(head[0]), .ccff_tail(tail[0]), .ccff_shift_en(sh_en[0]),
        .cfg_busy(busy[0]), .cfg_done(done[0]), .cfg_error(err[0]));

    ccff_bitstream_loader #(.CHAIN_LEN(LB), .WORD_W(W)) u_dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .cfg_start(start[1]), .s_word(if_b.slave),
        .ccff_head(head[1]), .ccff_tail(tail[1]), .ccff_shift_en(sh_en[1]),
        .cfg_busy(busy[1]), .cfg_done(done[1]), .cfg_error(err[1]));

    function automatic int len_of(input int k);
        return (k == 0) ? LA : LB;
    endfunction

    int          cyc = 0;
    int          acc_cnt [2] = '{0, 0};
    int          sh_cnt  [2] = '{0, 0};
    int          first_sh[2] = '{0, 0};
    int          last_ld [2] = '{0, 0};
    int          last_sh [2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    logic [11:0] chain   [2] = '{12'h0, 12'h0};
    logic [11:0] sent    [2] = '{12'h0, 12'h0};
    logic [1:0]  err_at_done = 2'b00;

    // Optional fault: invert the tail on the second rotate-back shift.
    assign tail[0] = chain[0][LA-1] ^ (flip[0] && (sh_cnt[0] == LA + 1));
    assign tail[1] = chain[1][LB-1] ^ (flip[1] && (sh_cnt[1] == LB + 1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (sh_en[k]) chain[k] <= {chain[k][10:0], head[k]};
            if (mon_clr[k]) begin
                acc_cnt[k] <= 0; sh_cnt[k] <= 0; done_cnt[k] <= 0;
                first_sh[k] <= -1; last_ld[k] <= -1; last_sh[k] <= -1; done_cyc[k] <= -1;
                sent[k] <= '0; err_at_done[k] <= 1'b0;
            end else begin
                if (v_valid[k] && ready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
                if (sh_en[k]) begin
                    sh_cnt[k]  <= sh_cnt[k] + 1;
                    last_sh[k] <= cyc;
                    if (sh_cnt[k] == 0) first_sh[k] <= cyc;
                    if (sh_cnt[k] < len_of(k)) begin
                        sent[k]    <= {sent[k][10:0], head[k]};
                        last_ld[k] <= cyc;
                    end
                end
                if (done[k]) begin
                    done_cnt[k]    <= done_cnt[k] + 1;
                    done_cyc[k]    <= cyc;
                    err_at_done[k] <= err[k];
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input int k, input logic [7:0] w0, input logic [7:0] w1,
                            input bit do_flip, input bit poke);
        int          L, nwords, n;
        logic [15:0] cat;
        logic [11:0] exp_bits, mask;
        logic [7:0]  junk;
        bit          poked;
        string       p;
        L        = len_of(k);
        nwords   = (L + W - 1) / W;
        cat      = {w0, w1};
        exp_bits = 12'(cat >> (16 - L));
        mask     = 12'((1 << L) - 1);
        junk     = 8'($urandom);
        p        = $sformatf("L%0d_w%02h", L, w0);
        @(negedge clk);
        flip[k] = do_flip; mon_clr[k] = 1'b1; start[k] = 1'b1;
        v_valid[k] = 1'b1; v_word[k] = w0;
        @(negedge clk);
        mon_clr[k] = 1'b0; start[k] = 1'b0;
        chk({p, "_ready_in_load"}, 32'(ready[k]), 32'd1);
        chk({p, "_busy_in_load"}, 32'(busy[k]), 32'd1);
        chk({p, "_error_cleared"}, 32'(err[k]), 32'd0);
        poked = 0;
        n = 0;
        while (!(done_cnt[k] > 0 && !busy[k]) && n < 100) begin
            v_word[k] = (acc_cnt[k] == 0) ? w0 : ((acc_cnt[k] == 1 && nwords > 1) ? w1 : junk);
            if (poke && !poked && sh_cnt[k] == 1) begin
                start[k] = 1'b1;
                poked = 1;
            end else begin
                start[k] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start[k] = 1'b0; v_valid[k] = 1'b0;
        chk({p, "_finished_in_budget"}, 32'(n < 100), 32'd1);
        chk({p, "_words_accepted"}, 32'(acc_cnt[k]), 32'(nwords));
        chk({p, "_shift_count"}, 32'(sh_cnt[k]), 32'(L * (1 + VER)));
        chk({p, "_bits_sent"}, 32'(sent[k] & mask), 32'(exp_bits));
        if (!do_flip) chk({p, "_chain_contents"}, 32'(chain[k] & mask), 32'(exp_bits));
        chk({p, "_shift_bubbles"}, 32'(last_ld[k] - first_sh[k] + 1 - L), 32'(nwords - 1));
        chk({p, "_done_pulses"}, 32'(done_cnt[k]), 32'd1);
        chk({p, "_done_after_last_shift"}, 32'(done_cyc[k]), 32'(last_sh[k] + 1));
        chk({p, "_busy_drop_cycle"}, 32'(cyc), 32'(done_cyc[k] + 1));
        chk({p, "_error_with_done"}, 32'(err_at_done[k]), 32'(do_flip));
        chk({p, "_error_sticky"}, 32'(err[k]), 32'(do_flip));
        flip[k] = 1'b0;
    endtask

    initial begin
        int n;
        v_word[0] = 8'h00;
        v_word[1] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_head_%0d", k), 32'(head[k]), 32'd0);
            chk($sformatf("reset_shift_en_%0d", k), 32'(sh_en[k]), 32'd0);
            chk($sformatf("reset_busy_%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("reset_done_%0d", k), 32'(done[k]), 32'd0);
            chk($sformatf("reset_error_%0d", k), 32'(err[k]), 32'd0);
            chk($sformatf("reset_ready_%0d", k), 32'(ready[k]), 32'd0);
        end
        rst_n = 1'b1;

        run_load(0, 8'hA5, 8'($urandom), 1'b0, 1'b0);
        run_load(1, 8'h3C, 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_load(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            run_load(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

`ifdef CCFF_VERIFY_EN
        run_load(0, 8'hC0, 8'($urandom), 1'b0, 1'b0);
        run_load(0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        run_load(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        run_load(1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        run_load(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
`endif

        // Reset while the third bit of 0xA5 (a 1) is on the chain input.
        @(negedge clk);
        mon_clr[0] = 1'b1; start[0] = 1'b1; v_valid[0] = 1'b1; v_word[0] = 8'hA5;
        @(negedge clk);
        mon_clr[0] = 1'b0; start[0] = 1'b0;
        n = 0;
        while (sh_cnt[0] != 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_bit2", 32'(n < 50), 32'd1);
        chk("midrst_shift_en_before", 32'(sh_en[0]), 32'd1);
        chk("midrst_head_before", 32'(head[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_shift_en", 32'(sh_en[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_head", 32'(head[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; v_valid[0] = 1'b0;
        run_load(0, 8'h5A, 8'($urandom), 1'b0, 1'b0);

        run_load(1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        run_load(0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
